// File: rtl/picorv32_mem_ctrl_pkg.sv
// Shared types and helpers for the picorv32 native-memory controller.
package picorv32_mem_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 32;

    typedef enum logic [1:0] {IDLE, READ, WRITE, PFETCH} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    // Byte-enable pattern of an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(size_e s);
        case (s)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/picorv32_mem_ctrl_if.sv
// Native valid/ready memory bus between the controller (master) and memory (slave).
interface picorv32_mem_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_instr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_ctrl_align.sv
// Byte-lane alignment: store strobes, store-data replication, load extraction.
module picorv32_mem_align
    import picorv32_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [$clog2(DW/8)-1:0] lane,
    input  logic [1:0]              size,
    input  logic [DW-1:0]           wdata_in,
    input  logic [DW-1:0]           rdata_in,
    output logic [DW/8-1:0]         wstrb,
    output logic [DW-1:0]           wdata,
    output logic [DW-1:0]           rdata
);
    localparam int SW = DW / 8;

    logic [7:0]    mask;
    logic [DW-1:0] shifted;
    logic [DW-1:0] bit_mask;

    // NOTE: every output and temporary gets a value on every path, so no latch is inferred.
    always_comb begin
        mask  = size_mask(size_e'(size));
        wstrb = SW'(mask << lane);
        case (size_e'(size))
            SZ_B:    wdata = {SW{wdata_in[7:0]}};
            SZ_H:    wdata = {(SW/2){wdata_in[15:0]}};
            SZ_W:    wdata = {(DW/32){wdata_in[31:0]}};
            default: wdata = wdata_in;
        endcase
        shifted  = rdata_in >> {lane, 3'b000};
        bit_mask = '0;
        for (int i = 0; i < SW; i++) begin
            bit_mask[8*i +: 8] = {8{mask[i]}};
        end
        rdata = shifted & bit_mask;
    end

endmodule

// File: rtl/picorv32_mem_ctrl.sv
// Request/complete sequencer for the picorv32 memory bus; MEM_CTRL_PREFETCH_EN adds a
// single-entry sequential instruction prefetch buffer.
module picorv32_mem_ctrl
    import picorv32_mem_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                trap,
    input  logic                req_rinst,
    input  logic                req_rdata,
    input  logic                req_wdata,
    input  logic [AW-1:0]       req_addr,
    input  logic [1:0]          req_size,
    input  logic [DW-1:0]       req_wdata_in,
    input  logic                clear_prefetch,
    picorv32_mem_ctrl_if.master mem,
    output logic                rsp_done,
    output logic [DW-1:0]       rsp_rdata,
    output logic                busy
);
    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);

    state_e        state;
    logic [LB-1:0] lane_q;
    logic [1:0]    size_q;
    logic [AW-1:0] req_base;
    logic [LB-1:0] al_lane;
    logic [1:0]    al_size;
    logic [DW-1:0] al_rdata_in;
    logic [SW-1:0] al_wstrb;
    logic [DW-1:0] al_wdata;
    logic [DW-1:0] al_rdata;

    assign req_base = {req_addr[AW-1:LB], {LB{1'b0}}};
    assign busy     = (state != IDLE);

`ifdef MEM_CTRL_PREFETCH_EN
    logic          pf_valid;
    logic          pf_discard;
    logic [AW-1:0] pf_addr;
    logic [DW-1:0] pf_data;
    logic          pf_hit;
    logic          any_req;

    assign pf_hit  = pf_valid && (pf_addr == req_base);
    assign any_req = req_rinst || req_rdata || req_wdata;
`else
    logic unused_clear_prefetch;
    assign unused_clear_prefetch = clear_prefetch;
`endif

    // In IDLE the aligner serves the incoming request; otherwise the captured transfer.
    always_comb begin
        al_lane     = (state == IDLE) ? req_addr[LB-1:0] : lane_q;
        al_size     = (state == IDLE) ? req_size : size_q;
        al_rdata_in = mem.mem_rdata;
`ifdef MEM_CTRL_PREFETCH_EN
        if (state == IDLE) al_rdata_in = pf_data;
`endif
    end

    picorv32_mem_align #(.DW(DW)) u_align (
        .lane     (al_lane),
        .size     (al_size),
        .wdata_in (req_wdata_in),
        .rdata_in (al_rdata_in),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .rdata    (al_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only; later assignments override earlier defaults.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            mem.mem_valid <= 1'b0;
            mem.mem_instr <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            rsp_done      <= 1'b0;
            rsp_rdata     <= '0;
            lane_q        <= '0;
            size_q        <= '0;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_valid      <= 1'b0;
            pf_discard    <= 1'b0;
            pf_addr       <= '0;
`endif
        end else begin
            rsp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!trap && (req_rinst || req_rdata || req_wdata)) begin
                        lane_q        <= req_addr[LB-1:0];
                        size_q        <= req_size;
                        mem.mem_addr  <= req_base;
                        mem.mem_valid <= 1'b1;
                        if (req_rinst || req_rdata) begin
                            mem.mem_instr <= req_rinst;
                            mem.mem_wstrb <= '0;
                            state         <= READ;
                        end else begin
                            mem.mem_instr <= 1'b0;
                            mem.mem_wstrb <= al_wstrb;
                            mem.mem_wdata <= al_wdata;
                            state         <= WRITE;
                        end
`ifdef MEM_CTRL_PREFETCH_EN
                        if (req_rinst) begin
                            pf_valid <= 1'b0;
                            if (pf_hit) begin
                                mem.mem_valid <= 1'b0;
                                mem.mem_instr <= 1'b0;
                                rsp_done      <= 1'b1;
                                rsp_rdata     <= al_rdata;
                                state         <= IDLE;
                            end
                        end
`endif
                    end
                end
                READ: begin
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        mem.mem_instr <= 1'b0;
                        rsp_done      <= 1'b1;
                        rsp_rdata     <= al_rdata;
                        state         <= IDLE;
`ifdef MEM_CTRL_PREFETCH_EN
                        if (mem.mem_instr && !trap && !any_req) begin
                            mem.mem_valid <= 1'b1;
                            mem.mem_instr <= 1'b1;
                            mem.mem_addr  <= mem.mem_addr + AW'(SW);
                            pf_discard    <= 1'b0;
                            state         <= PFETCH;
                        end
`endif
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        mem.mem_wstrb <= '0;
                        rsp_done      <= 1'b1;
                        state         <= IDLE;
`ifdef MEM_CTRL_PREFETCH_EN
                        pf_valid      <= 1'b0;
`endif
                    end
                end
`ifdef MEM_CTRL_PREFETCH_EN
                PFETCH: begin
                    if (clear_prefetch || trap) pf_discard <= 1'b1;
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        mem.mem_instr <= 1'b0;
                        pf_addr       <= mem.mem_addr;
                        pf_valid      <= !(pf_discard || clear_prefetch || trap);
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef MEM_CTRL_PREFETCH_EN
            if (clear_prefetch || trap) pf_valid <= 1'b0;
`endif
        end
    end

`ifdef MEM_CTRL_PREFETCH_EN
    // NOTE: the buffer data register is qualified by pf_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == PFETCH && mem.mem_ready) pf_data <= mem.mem_rdata;
    end
`endif

endmodule

// File: tb/tb_picorv32_mem_ctrl.sv
// Scoreboard bench for picorv32_mem_ctrl: a 32-bit and a 64-bit instance with bus responders.
module tb_picorv32_mem_ctrl;
    import picorv32_mem_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        trap32, rinst32, rdata32, wdata32, clr32;
    logic [31:0] addr32, wd32, rsp32;
    logic [1:0]  size32;
    logic        done32, busy32;

    logic        trap64, rinst64, rdata64, wdata64, clr64;
    logic [31:0] addr64;
    logic [63:0] wd64, rsp64;
    logic [1:0]  size64;
    logic        done64, busy64;

    picorv32_mem_ctrl_if #(.DW(32), .AW(32)) bus32 ();
    picorv32_mem_ctrl_if #(.DW(64), .AW(32)) bus64 ();

    picorv32_mem_ctrl #(.DW(32), .AW(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .trap(trap32), .req_rinst(rinst32), .req_rdata(rdata32),
        .req_wdata(wdata32), .req_addr(addr32), .req_size(size32), .req_wdata_in(wd32),
        .clear_prefetch(clr32), .mem(bus32), .rsp_done(done32), .rsp_rdata(rsp32), .busy(busy32)
    );

    picorv32_mem_ctrl #(.DW(64), .AW(32)) u_dut64 (
        .clk(clk), .resetn(resetn), .trap(trap64), .req_rinst(rinst64), .req_rdata(rdata64),
        .req_wdata(wdata64), .req_addr(addr64), .req_size(size64), .req_wdata_in(wd64),
        .clear_prefetch(clr64), .mem(bus64), .rsp_done(done64), .rsp_rdata(rsp64), .busy(busy64)
    );

    typedef struct {
        logic        is_read;
        logic [63:0] data;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          lat32 = 0;
    int          lat64 = 0;
    logic [63:0] rd64 = 64'h1122_3344_5566_7788;

    function automatic logic [31:0] mem32_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] exp_load32(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz);
        logic [31:0] s;
        s = word >> (8 * lane);
        case (sz)
            2'd0:    return s & 32'h0000_00FF;
            2'd1:    return s & 32'h0000_FFFF;
            default: return s;
        endcase
    endfunction

    // Memory models: ready after lat wait cycles, one-cycle ready pulse per transfer.
    initial begin
        int cnt;
        cnt = 0;
        bus32.mem_ready = 1'b0;
        bus32.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus32.mem_ready) begin
                bus32.mem_ready = 1'b0;
                cnt = 0;
            end else if (bus32.mem_valid) begin
                if (cnt >= lat32) begin
                    bus32.mem_ready = 1'b1;
                    bus32.mem_rdata = mem32_val(bus32.mem_addr);
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        bus64.mem_ready = 1'b0;
        bus64.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus64.mem_ready) begin
                bus64.mem_ready = 1'b0;
                cnt = 0;
            end else if (bus64.mem_valid) begin
                if (cnt >= lat64) begin
                    bus64.mem_ready = 1'b1;
                    bus64.mem_rdata = rd64;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Scoreboard checkers: every rsp_done pops one expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done32) begin
            tests_run++;
            if (q32.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp32_unexpected: rsp_done with empty scoreboard, rdata=%h", rsp32);
            end else begin
                e = q32.pop_front();
                if (e.is_read && rsp32 !== e.data[31:0]) begin
                    tests_failed++;
                    $display("FAIL rsp32_rdata: got %h expected %h", rsp32, e.data[31:0]);
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done64) begin
            tests_run++;
            if (q64.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp64_unexpected: rsp_done with empty scoreboard, rdata=%h", rsp64);
            end else begin
                e = q64.pop_front();
                if (e.is_read && rsp64 !== e.data) begin
                    tests_failed++;
                    $display("FAIL rsp64_rdata: got %h expected %h", rsp64, e.data);
                end
            end
        end
    end

    // kind: 0 = instruction fetch, 1 = load, 2 = store
    task automatic issue32(input int kind, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input bit push);
        exp_t e;
        addr32 = a; size32 = sz; wd32 = d;
        rinst32 = (kind == 0); rdata32 = (kind == 1); wdata32 = (kind == 2);
        if (push) begin
            e.is_read = (kind != 2);
            e.data    = {32'h0, exp_load32(mem32_val({a[31:2], 2'b00}), a[1:0], sz)};
            q32.push_back(e);
        end
        @(posedge clk); #1;
        rinst32 = 1'b0; rdata32 = 1'b0; wdata32 = 1'b0;
    endtask

    task automatic issue64(input int kind, input logic [31:0] a, input logic [1:0] sz,
                           input logic [63:0] d, input logic [63:0] expv);
        exp_t e;
        addr64 = a; size64 = sz; wd64 = d;
        rinst64 = (kind == 0); rdata64 = (kind == 1); wdata64 = (kind == 2);
        e.is_read = (kind != 2);
        e.data    = expv;
        q64.push_back(e);
        @(posedge clk); #1;
        rinst64 = 1'b0; rdata64 = 1'b0; wdata64 = 1'b0;
    endtask

    task automatic wait_done32(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done32) found = 1;
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: rsp_done got 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic wait_done64(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done64) found = 1;
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: rsp_done got 0 expected 1 within 40 cycles", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle32(input string name);
        bit idle;
        idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!busy32 && !bus32.mem_valid) idle = 1;
        end
        if (!idle) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_idle_timeout: busy got 1 expected 0 within 40 cycles", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus32.mem_valid, bus32.mem_instr, bus32.mem_wstrb, done32, busy32} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl32: got %b expected 0",
                     {bus32.mem_valid, bus32.mem_instr, bus32.mem_wstrb, done32, busy32});
        end
        tests_run++;
        if ({bus32.mem_addr, bus32.mem_wdata, rsp32} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data32: addr=%h wdata=%h rdata=%h expected 0",
                     bus32.mem_addr, bus32.mem_wdata, rsp32);
        end
        tests_run++;
        if ({bus64.mem_valid, bus64.mem_wstrb, bus64.mem_wdata, rsp64, busy64} !== '0) begin
            tests_failed++;
            $display("FAIL reset_64: valid=%b wstrb=%h wdata=%h rdata=%h expected 0",
                     bus64.mem_valid, bus64.mem_wstrb, bus64.mem_wdata, rsp64);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        lat32 = 20;
        issue32(1, 32'h100, 2'd2, 32'h0, 0);
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || busy32 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_start: valid=%b busy=%b expected 1 1", bus32.mem_valid, busy32);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({bus32.mem_valid, busy32, done32} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset_abort: valid/busy/done got %b expected 000",
                     {bus32.mem_valid, busy32, done32});
        end
        resetn = 1'b1;
        lat32 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_store32();
        int pulses;
        lat32 = 3;
        issue32(2, 32'h103, 2'd0, 32'h0000_00A5, 1);
        tests_run++;
        if (bus32.mem_addr !== 32'h100 || bus32.mem_wstrb !== 4'b1000 ||
            bus32.mem_wdata !== 32'hA5A5_A5A5 || bus32.mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL byte_store: addr=%h wstrb=%b wdata=%h expected 00000100 1000 a5a5a5a5",
                     bus32.mem_addr, bus32.mem_wstrb, bus32.mem_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus32.mem_valid !== 1'b1 || bus32.mem_addr !== 32'h100 ||
                bus32.mem_wstrb !== 4'b1000 || bus32.mem_wdata !== 32'hA5A5_A5A5 || done32 !== 1'b0) begin
                tests_failed++;
                $display("FAIL byte_store_hold%0d: valid=%b addr=%h wstrb=%b done=%b expected held",
                         i, bus32.mem_valid, bus32.mem_addr, bus32.mem_wstrb, done32);
            end
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done32) pulses++;
        end
        tests_run++;
        if (pulses !== 1 || bus32.mem_valid !== 1'b0 || bus32.mem_wstrb !== 4'b0000) begin
            tests_failed++;
            $display("FAIL byte_store_done: pulses=%0d valid=%b wstrb=%b expected 1 0 0000",
                     pulses, bus32.mem_valid, bus32.mem_wstrb);
        end
        lat32 = 0;
        @(posedge clk); #1;
        issue32(2, 32'h102, 2'd1, 32'h0000_BEEF, 1);
        tests_run++;
        if (bus32.mem_wstrb !== 4'b1100 || bus32.mem_wdata !== 32'hBEEF_BEEF) begin
            tests_failed++;
            $display("FAIL half_store: wstrb=%b wdata=%h expected 1100 beefbeef",
                     bus32.mem_wstrb, bus32.mem_wdata);
        end
        wait_idle32("half_store");
    endtask

    task automatic test_wide64();
        lat64 = 0;
        issue64(1, 32'h0E, 2'd1, 64'h0, 64'h1122);
        tests_run++;
        if (bus64.mem_addr !== 32'h08 || bus64.mem_wstrb !== 8'h00 || bus64.mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL half_load64: addr=%h wstrb=%h expected 00000008 00",
                     bus64.mem_addr, bus64.mem_wstrb);
        end
        wait_done64("half_load64");
        issue64(1, 32'h05, 2'd0, 64'h0, 64'h33);
        wait_done64("byte_load64");
        issue64(1, 32'h00, 2'd3, 64'h0, 64'h1122_3344_5566_7788);
        wait_done64("dword_load64");
        issue64(2, 32'h08, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h0);
        tests_run++;
        if (bus64.mem_wstrb !== 8'hFF || bus64.mem_wdata !== 64'h0123_4567_89AB_CDEF) begin
            tests_failed++;
            $display("FAIL dword_store64: wstrb=%h wdata=%h expected ff 0123456789abcdef",
                     bus64.mem_wstrb, bus64.mem_wdata);
        end
        wait_done64("dword_store64");
        issue64(2, 32'h0C, 2'd2, 64'h0000_0000_CAFE_F00D, 64'h0);
        tests_run++;
        if (bus64.mem_addr !== 32'h08 || bus64.mem_wstrb !== 8'hF0 ||
            bus64.mem_wdata !== 64'hCAFE_F00D_CAFE_F00D) begin
            tests_failed++;
            $display("FAIL word_store64: addr=%h wstrb=%h wdata=%h expected 00000008 f0 cafef00dcafef00d",
                     bus64.mem_addr, bus64.mem_wstrb, bus64.mem_wdata);
        end
        wait_done64("word_store64");
    endtask

    task automatic test_priority_trap();
        exp_t e;
        lat32 = 2;
        addr32 = 32'h300; size32 = 2'd2; wd32 = 32'h1234_5678;
        rinst32 = 1'b1; wdata32 = 1'b1;
        e.is_read = 1'b1;
        e.data = {32'h0, mem32_val(32'h300)};
        q32.push_back(e);
        @(posedge clk); #1;
        rinst32 = 1'b0;
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || bus32.mem_instr !== 1'b1 || bus32.mem_wstrb !== 4'h0) begin
            tests_failed++;
            $display("FAIL priority: valid=%b instr=%b wstrb=%b expected 1 1 0000",
                     bus32.mem_valid, bus32.mem_instr, bus32.mem_wstrb);
        end
        trap32 = 1'b1;
        wait_done32("trap_fetch");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus32.mem_valid !== 1'b0 || busy32 !== 1'b0) begin
                tests_failed++;
                $display("FAIL trap_block%0d: valid=%b busy=%b expected 0 0", i, bus32.mem_valid, busy32);
            end
        end
        trap32 = 1'b0;
        e.is_read = 1'b0;
        e.data = 64'h0;
        q32.push_back(e);
        @(posedge clk); #1;
        wdata32 = 1'b0;
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || bus32.mem_instr !== 1'b0 || bus32.mem_wstrb !== 4'hF ||
            bus32.mem_wdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL trap_release: valid=%b instr=%b wstrb=%b wdata=%h expected 1 0 1111 12345678",
                     bus32.mem_valid, bus32.mem_instr, bus32.mem_wstrb, bus32.mem_wdata);
        end
        wait_idle32("trap_release");
        lat32 = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6] = '{32'h100, 32'h101, 32'h102, 32'h107, 32'h10A, 32'h1FC};
        logic [1:0]  sizes [6] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
        lat32 = 0;
        for (int i = 0; i < 6; i++) begin
            issue32(1, addrs[i], sizes[i], 32'h0, 1);
            @(posedge clk); #1;
            tests_run++;
            if (done32 !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_latency%0d: rsp_done got %b expected 1 two cycles after request",
                         i, done32);
            end
        end
        wait_idle32("b2b");
    endtask

`ifdef MEM_CTRL_PREFETCH_EN
    task automatic test_prefetch();
        clr32 = 1'b1;
        @(posedge clk); #1;
        clr32 = 1'b0;
        issue32(0, 32'h200, 2'd2, 32'h0, 1);
        @(posedge clk); #1;
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || bus32.mem_addr !== 32'h204 || bus32.mem_instr !== 1'b1 ||
            bus32.mem_wstrb !== 4'h0) begin
            tests_failed++;
            $display("FAIL pf_issue: valid=%b addr=%h instr=%b expected 1 00000204 1",
                     bus32.mem_valid, bus32.mem_addr, bus32.mem_instr);
        end
        wait_idle32("pf_fill");
        issue32(0, 32'h204, 2'd2, 32'h0, 1);
        tests_run++;
        if (done32 !== 1'b1 || bus32.mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pf_hit: done=%b valid=%b expected 1 0", done32, bus32.mem_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus32.mem_valid !== 1'b0 || busy32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL pf_hit_nobus: valid=%b busy=%b expected 0 0", bus32.mem_valid, busy32);
        end
        issue32(0, 32'h204, 2'd2, 32'h0, 1);
        tests_run++;
        if (bus32.mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pf_consumed: valid=%b expected 1 (buffer used once)", bus32.mem_valid);
        end
        wait_idle32("pf_consumed");
    endtask

    task automatic test_prefetch_store();
        clr32 = 1'b1;
        @(posedge clk); #1;
        clr32 = 1'b0;
        issue32(0, 32'h200, 2'd2, 32'h0, 1);
        wait_idle32("pfs_fill");
        issue32(2, 32'h400, 2'd2, 32'hDEAD_BEEF, 1);
        wait_idle32("pfs_store");
        issue32(0, 32'h204, 2'd2, 32'h0, 1);
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || bus32.mem_addr !== 32'h204) begin
            tests_failed++;
            $display("FAIL pf_store_inval: valid=%b addr=%h expected 1 00000204",
                     bus32.mem_valid, bus32.mem_addr);
        end
        wait_idle32("pfs_refetch");
        issue32(0, 32'h200, 2'd2, 32'h0, 1);
        wait_idle32("pfc_fill");
        clr32 = 1'b1;
        @(posedge clk); #1;
        clr32 = 1'b0;
        issue32(0, 32'h204, 2'd2, 32'h0, 1);
        tests_run++;
        if (bus32.mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pf_clear_inval: valid=%b expected 1", bus32.mem_valid);
        end
        wait_idle32("pfc_refetch");
    endtask
`else
    task automatic test_no_prefetch();
        issue32(0, 32'h200, 2'd2, 32'h0, 1);
        @(posedge clk); #1;
        tests_run++;
        if (bus32.mem_valid !== 1'b0 || busy32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_pf_idle: valid=%b busy=%b expected 0 0", bus32.mem_valid, busy32);
        end
        issue32(0, 32'h204, 2'd2, 32'h0, 1);
        tests_run++;
        if (bus32.mem_valid !== 1'b1 || bus32.mem_addr !== 32'h204 || done32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_pf_bus: valid=%b addr=%h done=%b expected 1 00000204 0",
                     bus32.mem_valid, bus32.mem_addr, done32);
        end
        wait_idle32("no_pf");
    endtask
`endif

    initial begin
        trap32 = 0; rinst32 = 0; rdata32 = 0; wdata32 = 0; clr32 = 0;
        addr32 = '0; size32 = '0; wd32 = '0;
        trap64 = 0; rinst64 = 0; rdata64 = 0; wdata64 = 0; clr64 = 0;
        addr64 = '0; size64 = '0; wd64 = '0;

        test_reset();
        test_store32();
        test_wide64();
        test_priority_trap();
        test_back_to_back();
`ifdef MEM_CTRL_PREFETCH_EN
        test_prefetch();
        test_prefetch_store();
`else
        test_no_prefetch();
`endif
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (q32.size() != 0 || q64.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: pending32=%0d pending64=%0d expected 0 0",
                     q32.size(), q64.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_ctrl.md
Name: picorv32_mem_ctrl

Overview:
Parametrised native-memory-interface controller for the picorv32 core. It replaces the single-state fetch/load/store sequencer with a full request/complete state machine. It adds byte-lane alignment for sub-word and wide accesses, and an optional single-entry sequential instruction prefetch buffer. It sits between the core's execute/fetch logic and the external valid/ready memory bus.

Parameters:
DW, 32, bus data width; 32 or 64.
AW, 32, byte address width.
SW, DW/8, strobe width (derived, not overridable).
LB, $clog2(DW/8), number of address lane bits (derived).

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
trap  in  1  core trap; blocks new requests, lets an in-flight transfer finish
req_rinst  in  1  instruction fetch request
req_rdata  in  1  data load request
req_wdata  in  1  data store request
req_addr  in  AW  byte address of request
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (only legal when DW=64)
req_wdata_in  in  DW  store data, LSB-aligned
clear_prefetch  in  1  invalidate prefetch buffer
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accept/complete
mem_instr  out  1  current transfer is an instruction fetch
mem_addr  out  AW  lane-aligned address (low LB bits zero)
mem_wdata  out  DW  lane-replicated store data
mem_wstrb  out  SW  byte strobes; all zero for reads
mem_rdata  in  DW  bus read data
rsp_done  out  1  one-cycle completion pulse
rsp_rdata  out  DW  read data shifted to LSB, zero-extended to req_size
busy  out  1  state != IDLE

Behaviour:
- Reset: mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_done=0, rsp_rdata=0, state=IDLE, prefetch buffer invalid. Reset wins over every other input.
- States: IDLE, READ, WRITE, PFETCH (PFETCH exists only with the feature macro).
- IDLE: a request is accepted only when trap=0. Priority on simultaneous requests: rinst > rdata > wdata; losing requests are ignored and the requester must hold them.
  - Read request: mem_valid=1 and mem_instr=rinst on the next cycle; go to READ.
  - Write request: mem_valid=1 with mem_wstrb computed; go to WRITE.
- READ / WRITE: hold mem_valid, mem_addr, mem_wdata, mem_wstrb stable until mem_ready=1.
  - On the mem_ready cycle: drop mem_valid next cycle, pulse rsp_done, capture rsp_rdata (READ only), return to IDLE.
  - Minimum latency: request to rsp_done is 2 cycles (mem_ready high in the first valid cycle).
- mem_valid never deasserts before mem_ready, including during trap. Trap asserted mid-transfer: complete normally, then stay in IDLE while trap=1.
- Alignment:
  - lane = req_addr[LB-1:0].
  - wstrb = size mask ({1,3,F,FF}) << lane.
  - wdata = store data replicated across DW at 8·2^size granularity.
  - rsp_rdata = (mem_rdata >> 8·lane) masked to size.
  - Misaligned requests (lane not a multiple of the size) are not checked; behaviour follows the shift arithmetic truncated to DW.
- mem_wstrb is 0 in READ and IDLE.
- Request inputs are sampled only in IDLE. Changes while busy are ignored.

Optional Feature:
MEM_CTRL_PREFETCH_EN.
- Defined:
  - After an instruction READ completes, if trap=0 and no request is pending, enter PFETCH and issue an instruction fetch at completed address + DW/8.
  - PFETCH follows the same handshake as READ but does not pulse rsp_done; the returned data is stored in the buffer with its address and marked valid.
  - A later req_rinst hitting the buffered address completes from the buffer: rsp_done the next cycle, no bus transfer, buffer invalidated.
  - A request arriving during PFETCH waits for PFETCH to finish.
  - The buffer is invalidated by clear_prefetch, any WRITE completion, trap, or a rinst miss. clear_prefetch during PFETCH discards that fetch's data.
- Undefined: PFETCH state, buffer and address comparator are absent; every rinst goes to the bus.

Decomposition:
- Package picorv32_mem_pkg:
  - state enum (IDLE, READ, WRITE, PFETCH).
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - size-to-mask function.
  - default DW/AW constants.
- Sub-module picorv32_mem_align: combinational strobe, wdata replication and rdata extraction, parametrised by DW.

Test Plan:
1. Reset mid-transfer: req_rdata at 0x100, hold resetn=0 while mem_valid=1 -> next cycle mem_valid=0, state IDLE, rsp_done=0.
2. Byte store DW=32: addr 0x103, data 0xA5 -> mem_addr=0x100, mem_wstrb=4'b1000, mem_wdata=0xA5A5A5A5; mem_valid held across 3 wait cycles; rsp_done pulses once.
3. Half load DW=64: addr 0x0E, mem_rdata=0x1122_3344_5566_7788 -> rsp_rdata=0x1122, mem_wstrb=0.
4. Simultaneous req_rinst and req_wdata -> fetch issued with mem_instr=1, no strobes; trap raised during the fetch -> transfer completes, no new request while trap=1.
5. With MEM_CTRL_PREFETCH_EN: fetch 0x200 -> PFETCH at 0x204; rinst 0x204 -> rsp_done next cycle, mem_valid stays 0.
6. With MEM_CTRL_PREFETCH_EN: store between the two fetches -> rinst 0x204 goes to the bus.
